// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-access command sequencer.
package spi_reg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_WAIT,
    RD_PUSH,
    RD_IDLE
  } state_t;

  localparam int         CMD_RW_BIT     = 7;
  localparam logic [7:0] ERR_BYTE       = 8'hEE;
  localparam int         RD_TIMEOUT_DEF = 16;

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes a command byte and then streams auto-incrementing register writes or reads.
// Optional read watchdog is enabled with `define SPI_REG_CTRL_TIMEOUT_EN.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              busy,
  input  logic [7:0]        rx_dat,
  input  logic              rx_vld,
  output logic [7:0]        tx_dat,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdat,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdat,
  input  logic              reg_rvld,
  output logic              cmd_active,
  output logic              err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdat_n, txd_n;
  logic              we_n, re_n, cmd_n, err_n;
  logic              tmo_hit;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != RD_WAIT) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));
`else
  localparam int unused_rd_timeout = RD_TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // tx_vld is combinational so it can never be raised while tx_rdy is low.
  always_comb begin
    state_n = state;
    addr_n  = reg_addr;
    wdat_n  = reg_wdat;
    txd_n   = tx_dat;
    we_n    = 1'b0;
    re_n    = 1'b0;
    cmd_n   = cmd_active;
    err_n   = err;
    tx_vld  = 1'b0;
    if (reg_we) addr_n = reg_addr + 1'b1;
    if (!busy) begin
      state_n = IDLE;
      cmd_n   = 1'b0;
    end else if (start) begin
      state_n = CMD;
      cmd_n   = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        CMD: if (rx_vld) begin
          addr_n  = rx_dat[ADDR_W-1:0];
          cmd_n   = 1'b1;
          state_n = rx_dat[CMD_RW_BIT] ? WR : RD_REQ;
        end
        WR: if (rx_vld) begin
          wdat_n = rx_dat;
          we_n   = 1'b1;
        end
        RD_REQ: begin
          re_n    = 1'b1;
          state_n = RD_WAIT;
        end
        RD_WAIT: if (reg_rvld) begin
          txd_n   = reg_rdat;
          state_n = RD_PUSH;
        end else if (tmo_hit) begin
          txd_n   = ERR_BYTE;
          err_n   = 1'b1;
          state_n = RD_PUSH;
        end
        RD_PUSH: if (tx_rdy && !rst) begin
          tx_vld  = 1'b1;
          state_n = RD_IDLE;
        end
        RD_IDLE: if (rx_vld) begin
          addr_n  = reg_addr + 1'b1;
          state_n = RD_REQ;
        end
        default: ;
      endcase
      // A byte arriving before the previous fetch was handed over is an underrun.
      if (rx_vld && (state == RD_REQ || state == RD_WAIT || state == RD_PUSH))
        err_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_addr   <= '0;
      reg_wdat   <= '0;
      tx_dat     <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      cmd_active <= 1'b0;
      err        <= 1'b0;
    end else begin
      reg_addr   <= addr_n;
      reg_wdat   <= wdat_n;
      tx_dat     <= txd_n;
      reg_we     <= we_n;
      reg_re     <= re_n;
      cmd_active <= cmd_n;
      err        <= err_n;
    end
  end

endmodule
